// File: rtl/wlx_dds_pkg.sv
// wlx_dds_pkg: shared DDS widths, midscale, latency and sine table generation (WLX_DDS_QUARTER_EN selects quarter-wave latency)
package wlx_dds_pkg;
  localparam int ACC_W_DEF = 32;
  localparam int ADDR_W_DEF = 6;
  localparam int DAT_W_DEF = 8;
`ifdef WLX_DDS_QUARTER_EN
  localparam int LAT = 3;
  localparam bit QUARTER_DEF = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit QUARTER_DEF = 1'b0;
`endif
  function automatic int midscale(int dat_w);
    return 1 << (dat_w - 1);
  endfunction
  function automatic real sine_of(int i, int addr_w);
    return $sin(2.0 * 3.14159265358979 * real'(i) / real'(1 << addr_w));
  endfunction
  function automatic int sine_mag(int i, int addr_w, int dat_w);
    real x;
    x = sine_of(i, addr_w);
    return $rtoi((x < 0.0 ? -x : x) * real'(midscale(dat_w) - 1) + 0.5);
  endfunction
  function automatic int sine_sample(int i, int addr_w, int dat_w);
    return sine_of(i, addr_w) < 0.0 ? midscale(dat_w) - sine_mag(i, addr_w, dat_w)
                                     : midscale(dat_w) + sine_mag(i, addr_w, dat_w);
  endfunction
endpackage

// File: rtl/wlx_fsk_dds_if.sv
// wlx_fsk_dds_if: symbol-source controls into the DDS and the sample stream out to the DA driver
interface wlx_fsk_dds_if import wlx_dds_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int DAT_W = DAT_W_DEF
);
  logic en;
  logic fsk_bit;
  logic [ACC_W-1:0] fword0;
  logic [ACC_W-1:0] fword1;
  logic [DAT_W-1:0] dat_out;
  logic dat_valid;
  logic cyc_tick;
  modport master (output en, fsk_bit, fword0, fword1, input dat_out, dat_valid, cyc_tick);
  modport slave (input en, fsk_bit, fword0, fword1, output dat_out, dat_valid, cyc_tick);
endinterface

// File: rtl/wlx_sine_rom.sv
// wlx_sine_rom: synchronous offset-binary sine ROM, full table or quarter-wave folded through one extra register
module wlx_sine_rom import wlx_dds_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DAT_W = DAT_W_DEF,
  parameter bit QUARTER = 1'b0
) (
  input logic clk,
  input logic [ADDR_W-1:0] address,
  output logic [DAT_W-1:0] q
);
  localparam logic [DAT_W-1:0] MID = DAT_W'(midscale(DAT_W));
  if (QUARTER) begin : g_quarter
    localparam int QN = 1 << (ADDR_W - 2);
    logic [DAT_W-1:0] tbl [QN];
    logic [ADDR_W-2:0] idx;
    logic [DAT_W-1:0] mag;
    logic neg;
    for (genvar i = 0; i < QN; i++) begin : g_tbl
      assign tbl[i] = DAT_W'(sine_mag(i, ADDR_W, DAT_W));
    end
    assign idx = address[ADDR_W-2] ? (ADDR_W-1)'(QN) - {1'b0, address[ADDR_W-3:0]}
                                   : {1'b0, address[ADDR_W-3:0]};
    always_ff @(posedge clk) begin
      mag <= idx[ADDR_W-2] ? MID - 1'b1 : tbl[idx[ADDR_W-3:0]];
      neg <= address[ADDR_W-1];
      q <= neg ? MID - mag : MID + mag;
    end
  end else begin : g_full
    logic [DAT_W-1:0] tbl [1 << ADDR_W];
    for (genvar i = 0; i < (1 << ADDR_W); i++) begin : g_tbl
      assign tbl[i] = DAT_W'(sine_sample(i, ADDR_W, DAT_W));
    end
    always_ff @(posedge clk) q <= tbl[address];
  end
endmodule

// File: rtl/wlx_fsk_dds.sv
// wlx_fsk_dds: FSK phase-accumulator DDS, word switch at wrap or immediate (WLX_DDS_QUARTER_EN: quarter-wave ROM, latency 3)
module wlx_fsk_dds import wlx_dds_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DAT_W = DAT_W_DEF,
  parameter bit SYNC_SWITCH = 1'b1
) (
  input logic clk,
  input logic rst_n,
  wlx_fsk_dds_if.slave bus
);
  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] nxt;
  logic wrap;
  logic sel;
  logic [LAT:0] vld_sr;
  logic [LAT:0] tck_sr;
  logic [DAT_W-1:0] q;
  assign {wrap, nxt} = {1'b0, phase} + {1'b0, sel ? bus.fword1 : bus.fword0};
  assign bus.dat_valid = vld_sr[LAT];
  assign bus.cyc_tick = tck_sr[LAT];
  wlx_sine_rom #(.ADDR_W(ADDR_W), .DAT_W(DAT_W), .QUARTER(QUARTER_DEF)) u_rom (
    .clk(clk),
    .address(phase[ACC_W-1 -: ADDR_W]),
    .q(q)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      phase <= '0;
      sel <= 1'b0;
      vld_sr <= '0;
      tck_sr <= '0;
      bus.dat_out <= DAT_W'(midscale(DAT_W));
    end else begin
      if (bus.en) phase <= nxt;
      if (!SYNC_SWITCH || (bus.en && wrap)) sel <= bus.fsk_bit;
      vld_sr <= {vld_sr[LAT-1:0], bus.en};
      tck_sr <= {tck_sr[LAT-1:0], bus.en & wrap};
      if (vld_sr[LAT-1]) bus.dat_out <= q;
    end
endmodule
